// File: rtl/mem_bus_master.sv
// Initiator-side load/store unit driving the MOV/RW/MOC four-phase handshake to a byte-addressed RAM.
// Optional MOC watchdog enabled by defining WATCHDOG_EN (aborts a phase after TIMEOUT cycles).
module mem_bus_master #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [5:0]        opcode,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              MOV,
   output logic              RW,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [5:0]        OpC,
   input  logic              MOC,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT_HI,
      WAIT_LO,
      FIN
   } state_t;

   state_t              state_q;
   logic [5:0]          op_q;
   logic [31:0]         addr_q;
   logic [31:0]         wdata_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic [31:0]         rdata_q;
   logic                mov_q;
   logic                rw_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [5:0]          opc_q;

   logic                op_legal;
   logic                align_ok;
   logic                range_ok;
   logic                chk_ok;
   logic [31:0]         rdata_d;

`ifdef WATCHDOG_EN
   localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [WD_W-1:0]     wd_q;
   logic                wd_expired;
   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
`endif

   always_comb begin
      op_legal = 1'b0;
      case (op_q)
         6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
         6'b101000, 6'b101001, 6'b101011: op_legal = 1'b1;
         default:                         op_legal = 1'b0;
      endcase

      // opcode[1:0] encodes access size: 00 byte, 01 halfword, 11 word
      align_ok = 1'b0;
      case (op_q[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = ~addr_q[0];
         2'b11:   align_ok = (addr_q[1:0] == 2'b00);
         default: align_ok = 1'b0;
      endcase

      range_ok = ~|addr_q[31:ADDR_W];
      chk_ok   = op_legal & align_ok & range_ok;

      rdata_d = mem_rdata;
      case (opc_q[2:0])
         3'b000:  rdata_d = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b100:  rdata_d = {24'h000000, mem_rdata[7:0]};
         3'b001:  rdata_d = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b101:  rdata_d = {16'h0000, mem_rdata[15:0]};
         default: rdata_d = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mov_q       <= 1'b0;
         rw_q        <= 1'b1;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         opc_q       <= '0;
`ifdef WATCHDOG_EN
         wd_q        <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  op_q    <= opcode;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  busy_q  <= 1'b1;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               if (!chk_ok) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  mem_addr_q  <= addr_q[ADDR_W-1:0];
                  mem_wdata_q <= wdata_q;
                  opc_q       <= op_q;
                  rw_q        <= ~op_q[3];
                  mov_q       <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef WATCHDOG_EN
               wd_q    <= '0;
`endif
               state_q <= WAIT_HI;
            end
            WAIT_HI: begin
               if (MOC) begin
                  if (rw_q) rdata_q <= rdata_d;
                  mov_q   <= 1'b0;
`ifdef WATCHDOG_EN
                  wd_q    <= '0;
`endif
                  state_q <= WAIT_LO;
               end
`ifdef WATCHDOG_EN
               else if (wd_expired) begin
                  mov_q   <= 1'b0;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  wd_q    <= wd_q + WD_W'(1);
               end
`endif
            end
            WAIT_LO: begin
               if (!MOC) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= FIN;
               end
`ifdef WATCHDOG_EN
               else if (wd_expired) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  wd_q    <= wd_q + WD_W'(1);
               end
`endif
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign MOV       = mov_q;
   assign RW        = rw_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign OpC       = opc_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: a one-cycle-lag MOC responder plus hand-computed expectations.
module tb_mem_bus_master;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BAD = 6'b100010;

   logic        clk;
   logic        reset;
   logic        req;
   logic [5:0]  opcode;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        MOV;
   logic        RW;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [5:0]  OpC;
   logic        MOC;
   logic [31:0] mem_rdata;

   logic        moc_auto;
   logic        moc_force_en;
   logic        moc_force;

   int          n_total;
   int          n_bad;

   int          t_done_cyc;
   int          t_err_cyc;
   int          t_mov_cnt;
   int          t_done_cnt;
   int          t_err_cnt;
   logic        t_stable;
   logic        t_busy1;
   logic        t_rw;
   logic [5:0]  t_opc;
   logic [8:0]  t_maddr;
   logic [31:0] t_mwdata;

   mem_bus_master #(
      .ADDR_W  (9),
      .TIMEOUT (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .opcode    (opcode),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .MOV       (MOV),
      .RW        (RW),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .OpC       (OpC),
      .MOC       (MOC),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM responder: MOC follows MOV one cycle later in both directions
   always @(posedge clk or negedge reset) begin
      if (!reset) moc_auto <= 1'b0;
      else        moc_auto <= MOV;
   end
   assign MOC = moc_force_en ? moc_force : moc_auto;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Cycle c is the c-th falling edge after the edge that accepts req
   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
      logic seen_mov;
      int   last;
      t_done_cyc = -1; t_err_cyc = -1; t_mov_cnt = 0; t_done_cnt = 0; t_err_cnt = 0;
      t_stable = 1'b1; t_busy1 = 1'b0; seen_mov = 1'b0; last = 60;
      @(negedge clk);
      req = 1'b1; opcode = op; addr = a; wdata = wd;
      @(posedge clk);
      #1 req = 1'b0;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (c == 1) t_busy1 = busy;
         if (MOV) begin
            if (!seen_mov) begin
               seen_mov = 1'b1;
               t_rw = RW; t_opc = OpC; t_maddr = mem_addr; t_mwdata = mem_wdata;
            end else if (RW !== t_rw || OpC !== t_opc || mem_addr !== t_maddr || mem_wdata !== t_mwdata) begin
               t_stable = 1'b0;
            end
            t_mov_cnt++;
         end
         if (done) begin
            t_done_cnt++;
            if (t_done_cyc < 0) begin t_done_cyc = c; last = c + 3; end
         end
         if (err) begin
            t_err_cnt++;
            if (t_err_cyc < 0) begin t_err_cyc = c; last = c + 3; end
         end
      end
   endtask

   task automatic check_err_op(input string tag, input logic [5:0] op, input logic [31:0] a);
      run_op(op, a, 32'h0);
      check_val({tag, "_err_cyc"}, t_err_cyc, 2);
      check_val({tag, "_err_cnt"}, t_err_cnt, 1);
      check_val({tag, "_no_mov"}, t_mov_cnt, 0);
      check_val({tag, "_no_done"}, t_done_cnt, 0);
      check_val({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic check_load(input string tag, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] raw, input logic [31:0] exp);
      mem_rdata = raw;
      run_op(op, a, 32'h0);
      check_val({tag, "_rdata"}, rdata, exp);
      check_val({tag, "_done_cyc"}, t_done_cyc, 6);
      check_val({tag, "_done_cnt"}, t_done_cnt, 1);
   endtask

   int first_low;
   int errc;
   logic [31:0] prev_rdata;

   initial begin
      n_total = 0; n_bad = 0;
      reset = 1'b0; req = 1'b1; opcode = OP_LW; addr = 32'h4; wdata = 32'hFFFF_FFFF;
      mem_rdata = 32'h0; moc_force_en = 1'b0; moc_force = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_ctl", {busy, done, err, MOV, RW}, 32'h1);
      check_val("rst_rdata", rdata, 32'h0);
      check_val("rst_bus", {OpC, mem_addr}, 32'h0);
      check_val("rst_wdata", mem_wdata, 32'h0);
      req = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_val("idle_after_rst", {busy, MOV, done, err}, 32'h0);

      // LW: latency from accepting edge to done edge is 5 clocks
      mem_rdata = 32'hDEAD_BEEF;
      run_op(OP_LW, 32'h4, 32'h0);
      check_val("lw_busy", t_busy1, 1);
      check_val("lw_mov_cnt", t_mov_cnt, 2);
      check_val("lw_rw", t_rw, 1);
      check_val("lw_opc", t_opc, 32'h23);
      check_val("lw_maddr", t_maddr, 32'h4);
      check_val("lw_stable", t_stable, 1);
      check_val("lw_rdata", rdata, 32'hDEAD_BEEF);
      check_val("lw_done_cyc", t_done_cyc, 6);
      check_val("lw_done_cnt", t_done_cnt, 1);
      check_val("lw_err_cnt", t_err_cnt, 0);
      check_val("lw_busy_end", busy, 0);

      check_load("lb",  OP_LB,  32'h3, 32'h0000_0080, 32'hFFFF_FF80);
      check_load("lbu", OP_LBU, 32'h3, 32'h0000_0080, 32'h0000_0080);
      check_load("lh",  OP_LH,  32'h2, 32'h0001_8001, 32'hFFFF_8001);
      check_load("lhu", OP_LHU, 32'h2, 32'h0001_8001, 32'h0000_8001);

      check_err_op("sh_mis",  OP_SH,  32'h1);
      check_err_op("sw_rng",  OP_SW,  32'h200);
      check_err_op("lw_mis",  OP_LW,  32'h2);
      check_err_op("bad_op",  OP_BAD, 32'h0);

      mem_rdata = 32'h5555_5555;
      run_op(OP_SB, 32'h10, 32'h1234_56AB);
      check_val("sb_rw", t_rw, 0);
      check_val("sb_mwdata", t_mwdata, 32'h1234_56AB);
      check_val("sb_opc", t_opc, 32'h28);
      check_val("sb_maddr", t_maddr, 32'h10);
      check_val("sb_stable", t_stable, 1);
      check_val("sb_mov_cnt", t_mov_cnt, 2);
      check_val("sb_done_cnt", t_done_cnt, 1);
      check_val("sb_rdata_keep", rdata, 32'h0000_8001);

      // reset while MOV is high
      mem_rdata = 32'h7777_7777;
      @(negedge clk);
      req = 1'b1; opcode = OP_LW; addr = 32'h8; wdata = 32'h0;
      @(posedge clk);
      #1 req = 1'b0;
      repeat (2) @(negedge clk);
      check_val("mid_mov_pre", MOV, 1);
      reset = 1'b0;
      #1 check_val("mid_mov_async", MOV, 0);
      @(negedge clk);
      reset = 1'b1;
      errc = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done || err || MOV || busy) errc++;
      end
      check_val("mid_quiet", errc, 0);
      check_val("mid_rdata", rdata, 32'h0);

      // MOC stuck low
      moc_force_en = 1'b1; moc_force = 1'b0;
      mem_rdata = 32'hCAFE_F00D;
      prev_rdata = rdata;
      @(negedge clk);
      req = 1'b1; opcode = OP_LW; addr = 32'h8;
      @(posedge clk);
      #1 req = 1'b0;
      first_low = -1; errc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c >= 3 && !MOV && first_low < 0) first_low = c;
         if (err && errc < 0) errc = c;
      end
`ifdef WATCHDOG_EN
      check_val("wd_err_cyc", errc, 18);
      check_val("wd_mov_drop", first_low, 18);
      check_val("wd_rdata_keep", rdata, prev_rdata);
      check_val("wd_busy", busy, 0);
      moc_force_en = 1'b0;
      run_op(OP_LW, 32'h8, 32'h0);
      check_val("wd_next_done", t_done_cyc, 6);
      check_val("wd_next_rdata", rdata, 32'hCAFE_F00D);
`else
      check_val("hang_no_err", errc, -1);
      check_val("hang_mov_held", first_low, -1);
      check_val("hang_busy", busy, 1);
      moc_force_en = 1'b0;
      errc = -1;
      for (int c = 1; c <= 20 && errc < 0; c++) begin
         @(negedge clk);
         if (done) errc = c;
      end
      check_val("hang_release_done", errc > 0, 1);
      check_val("hang_release_rdata", rdata, 32'hCAFE_F00D);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got=stuck exp=finish");
      $fatal(1);
   end

endmodule
